// File: rtl/demux1_8_tdm_if.sv
// Signal bundle for the receive side of the 8:1 TDM link.
// The master drives the serial stream; the slave (the demultiplexer) returns the frame outputs.
interface demux1_8_tdm_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             sync;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] y1;
  logic [WIDTH-1:0] y2;
  logic [WIDTH-1:0] y3;
  logic [WIDTH-1:0] y4;
  logic [WIDTH-1:0] y5;
  logic [WIDTH-1:0] y6;
  logic [WIDTH-1:0] y7;
  logic             frame_valid;
  logic             locked;
  logic [2:0]       slot;
  logic             sync_err;

  modport master (
    output din, din_valid, sync,
    input  y0, y1, y2, y3, y4, y5, y6, y7, frame_valid, locked, slot, sync_err
  );

  modport slave (
    input  din, din_valid, sync,
    output y0, y1, y2, y3, y4, y5, y6, y7, frame_valid, locked, slot, sync_err
  );
endinterface

// File: rtl/demux1_8_tdm.sv
// 1:8 TDM demultiplexer: aligns to the frame using sync, stages the 8 slots,
// and publishes each completed frame on registered parallel outputs.
module demux1_8_tdm #(
  parameter int unsigned WIDTH = 1
) (
  input  logic           clk,
  input  logic           rst,
  demux1_8_tdm_if.slave  bus
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [2:0]       slot_q, slot_nxt;
  logic [WIDTH-1:0] st [8];
  logic [WIDTH-1:0] y  [8];
  logic             fv_q, err_q;

  logic             accept, restart;
  logic [2:0]       wr_idx;
  logic             frame_done, err_set;

  // A sync in HUNT and a sync at a non-zero slot both restart the frame at slot 0.
  assign accept  = bus.din_valid && ((state == LOCKED) || bus.sync);
  assign restart = bus.din_valid && bus.sync && ((state == HUNT) || (slot_q != 3'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= HUNT;
      slot_q <= '0;
    end else begin
      state  <= state_nxt;
      slot_q <= slot_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    slot_nxt  = slot_q;
    if (accept) begin
      state_nxt = LOCKED;
      slot_nxt  = restart ? 3'd1 : slot_q + 3'd1;
    end
  end

  always_comb begin
    wr_idx     = restart ? 3'd0 : slot_q;
    frame_done = accept && !restart && (slot_q == 3'd7);
    err_set    = restart && (state == LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 8; i++) begin
        st[i] <= '0;
        y[i]  <= '0;
      end
      fv_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (accept && (wr_idx == 3'(i))) st[i] <= bus.din;
      end
      // Slot 7 bypasses staging so the whole frame lands on y in one edge.
      if (frame_done) begin
        for (int unsigned i = 0; i < 7; i++) y[i] <= st[i];
        y[7] <= bus.din;
      end
      fv_q  <= frame_done;
      err_q <= err_set;
    end
  end

  assign bus.y0          = y[0];
  assign bus.y1          = y[1];
  assign bus.y2          = y[2];
  assign bus.y3          = y[3];
  assign bus.y4          = y[4];
  assign bus.y5          = y[5];
  assign bus.y6          = y[6];
  assign bus.y7          = y[7];
  assign bus.frame_valid = fv_q;
  assign bus.sync_err    = err_q;
  assign bus.locked      = (state == LOCKED);
  assign bus.slot        = slot_q;

endmodule
